// File: rtl/gx_fifo_pkg.sv
// gx_fifo_pkg: shared FSM states and burst geometry for the GX FIFO burst writer.
package gx_fifo_pkg;
   typedef enum logic [2:0] {IDLE, POP0, POP1, CAP, BEAT0, BEAT1} gxState;
   localparam int BURST_BYTES = 32;
   localparam int BEAT_BYTES  = 16;
   localparam int PTR_ALIGN   = 5;
endpackage

// File: rtl/gx_fifo_burst_writer_if.sv
// gx_fifo_burst_writer_if: gather-buffer pop channel and memory write-beat channel.
interface gx_fifo_burst_writer_if #(parameter int ADDR_W = 26);
   logic              gp_full;
   logic              gp_read;
   logic [127:0]      gp_data;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [127:0]      mem_wdata;
   logic              mem_last;
   logic              mem_ack;
   modport master (input gp_full, gp_data, mem_ack, output gp_read, mem_req, mem_addr, mem_wdata, mem_last);
   modport slave  (output gp_full, gp_data, mem_ack, input gp_read, mem_req, mem_addr, mem_wdata, mem_last);
endinterface

// File: rtl/gx_fifo_distance.sv
// gx_fifo_distance: bytes queued between consumer and producer pointers in a circular FIFO.
module gx_fifo_distance
   import gx_fifo_pkg::*;
#(
   parameter int ADDR_W = 26
) (
   input  logic [ADDR_W-1:0] wrPtr,
   input  logic [ADDR_W-1:0] rdPtr,
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] endAddr,
   output logic [ADDR_W-1:0] count
);
   // end is the last slot inclusive, so the ring spans end + one burst - base
   always_comb count = (wrPtr >= rdPtr) ? wrPtr - rdPtr
                     : (endAddr + ADDR_W'(BURST_BYTES) - base) - (rdPtr - wrPtr);
endmodule

// File: rtl/gx_fifo_burst_writer.sv
// gx_fifo_burst_writer: drains 32-byte gather lines as two-beat bursts into the GX FIFO ring
// and raises watermark interrupts from the fill level.
module gx_fifo_burst_writer
   import gx_fifo_pkg::*;
#(
   parameter int ADDR_W = 26
) (
   input  logic                   clk,
   input  logic                   resetn,
   gx_fifo_burst_writer_if.master bus,
   input  logic                   cfg_enable,
   input  logic [ADDR_W-1:0]      cfg_base,
   input  logic [ADDR_W-1:0]      cfg_end,
   input  logic [ADDR_W-1:0]      cfg_hiwat,
   input  logic [ADDR_W-1:0]      cfg_lowat,
   input  logic                   cfg_wptr_load,
   input  logic [ADDR_W-1:0]      cfg_wptr_val,
   input  logic [ADDR_W-1:0]      rd_ptr,
   output logic [ADDR_W-1:0]      wr_ptr,
   output logic [ADDR_W-1:0]      fifo_count,
   output logic                   hi_irq,
   output logic                   lo_irq,
   output logic                   busy
);
   gxState            state, nextState;
   logic [127:0]      lineLo, lineHi;
   logic [ADDR_W-1:0] countNext;
   gx_fifo_distance #(.ADDR_W(ADDR_W)) distance (
      .wrPtr  (wr_ptr),
      .rdPtr  (rd_ptr),
      .base   (cfg_base),
      .endAddr(cfg_end),
      .count  (countNext)
   );
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         lineLo     <= '0;
         lineHi     <= '0;
         fifo_count <= '0;
         hi_irq     <= 1'b0;
         lo_irq     <= 1'b0;
      end else begin
         state <= nextState;
         if (state == POP1) lineLo <= bus.gp_data;
         if (state == CAP) lineHi <= bus.gp_data;
         // software may only move the pointer while the writer is idle and disabled
         if (state == IDLE && !cfg_enable && cfg_wptr_load)
            wr_ptr <= cfg_wptr_val & ~ADDR_W'(BURST_BYTES - 1);
         else if (state == BEAT1 && bus.mem_ack)
            wr_ptr <= (wr_ptr == cfg_end) ? cfg_base : wr_ptr + ADDR_W'(BURST_BYTES);
         fifo_count <= countNext;
         hi_irq     <= fifo_count > cfg_hiwat;
         lo_irq     <= fifo_count < cfg_lowat;
      end
   end
   always_comb begin
      nextState     = state;
      bus.gp_read   = state == POP0 || state == POP1;
      bus.mem_req   = state == BEAT0 || state == BEAT1;
      bus.mem_last  = state == BEAT1;
      bus.mem_addr  = bus.mem_last ? wr_ptr + ADDR_W'(BEAT_BYTES) : wr_ptr;
      bus.mem_wdata = bus.mem_last ? lineHi : lineLo;
      busy          = state != IDLE;
      case (state)
         IDLE:    nextState = (cfg_enable && bus.gp_full) ? POP0 : IDLE;
         POP0:    nextState = POP1;
         POP1:    nextState = CAP;
         CAP:     nextState = BEAT0;
         BEAT0:   nextState = bus.mem_ack ? BEAT1 : BEAT0;
         BEAT1:   nextState = bus.mem_ack ? IDLE : BEAT1;
         default: nextState = IDLE;
      endcase
   end
endmodule
